// File: rtl/signed_divider_if.sv
// Operand/result bundle for the sequential signed divider.
// master drives the request side; slave is the divider itself.
interface signed_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, A, B,
        input  Quotient, Remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output Quotient, Remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/signed_divider.sv
// Signed restoring divider, one quotient bit per clock on operand magnitudes.
// Latency WIDTH+2 from accepting edge to done; start is ignored while busy.
module signed_divider #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    signed_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovfo_q, ovfo_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] most_neg;

    assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    // Partial remainder stays below |B| <= 2^(WIDTH-1), so WIDTH+1 bits never wrap.
    assign shifted  = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, bmag_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        a_d     = a_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovfo_d  = ovfo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    sgnq_d  = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    sgnr_d  = bus.A[WIDTH-1];
                    dvd_d   = bus.A[WIDTH-1] ? -bus.A : bus.A;
                    bmag_d  = bus.B[WIDTH-1] ? -bus.B : bus.B;
                    a_d     = bus.A;
                    rem_d   = '0;
                    cnt_d   = '0;
                    zero_d  = (bus.B == '0);
                    ovf_d   = (bus.A == most_neg) && (bus.B == '1);
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = WIDTH'(trial);
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = WIDTH'(shifted);
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbz_d   = zero_q;
                ovfo_d  = ovf_q && !zero_q;
                if (zero_q) begin
                    quo_d  = '1;
                    remo_d = a_q;
                end else if (ovf_q) begin
                    quo_d  = most_neg;
                    remo_d = '0;
                end else begin
                    quo_d  = sgnq_q ? -dvd_q : dvd_q;
                    remo_d = sgnr_q ? -rem_q : rem_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            a_q     <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            a_q     <= a_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovfo_q  <= ovfo_d;
        end
    end

    assign bus.Quotient    = quo_q;
    assign bus.Remainder   = remo_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovfo_q;
endmodule

// File: tb/tb_signed_divider.sv
// Bench for signed_divider: directed vector table, handshake/reset sequences,
// and a random sweep against a truncating-division reference.
module tb_signed_divider;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    signed_divider_if #(.WIDTH(16)) bus ();

    signed_divider #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else if (ai == -32768 && bi == -1) begin
            q  = 16'h8000;
            r  = 16'h0000;
            ov = 1'b1;
        end else begin
            q = 16'(ai / bi);
            r = 16'(ai % bi);
        end
    endfunction

    // Starts one operation, scrambles operands after acceptance, waits for done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic dz, output logic ov, output int dcyc,
                          output logic busy_at_done);
        int c;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 16'($urandom);
        dcyc = -1;
        c    = 1;
        while (c <= 40 && dcyc < 0) begin
            if (bus.done) begin
                dcyc = c;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        q            = bus.Quotient;
        r            = bus.Remainder;
        dz           = bus.div_by_zero;
        ov           = bus.overflow;
        busy_at_done = bus.busy;
    endtask

    initial begin
        logic [15:0] q, r, eq, er, a1, b1, ra, rb;
        logic        dz, ov, edz, eov, bz;
        int          dcyc, ndone, dfirst;
        int          dpos[$];
        int          qi, ri, ai, bi;

        checks = 0;
        errors = 0;

        tbl[0]  = '{16'd100,    16'd7,      16'd14,     16'd2,      1'b0, 1'b0};
        tbl[1]  = '{16'hFF9C,   16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 1'b0};
        tbl[2]  = '{16'd100,    16'hFFF9,   16'hFFF2,   16'd2,      1'b0, 1'b0};
        tbl[3]  = '{16'hFFF9,   16'hFFFA,   16'd1,      16'hFFFF,   1'b0, 1'b0};
        tbl[4]  = '{16'hFFF9,   16'h0000,   16'hFFFF,   16'hFFF9,   1'b1, 1'b0};
        tbl[5]  = '{16'h8000,   16'hFFFF,   16'h8000,   16'h0000,   1'b0, 1'b1};
        tbl[6]  = '{16'h8000,   16'd1,      16'h8000,   16'h0000,   1'b0, 1'b0};
        tbl[7]  = '{16'd1000,   16'd3,      16'd333,    16'd1,      1'b0, 1'b0};
        tbl[8]  = '{16'd7,      16'd100,    16'd0,      16'd7,      1'b0, 1'b0};
        tbl[9]  = '{16'hFFFF,   16'd2,      16'd0,      16'hFFFF,   1'b0, 1'b0};
        tbl[10] = '{16'h7FFF,   16'hFFFF,   16'h8001,   16'h0000,   1'b0, 1'b0};
        tbl[11] = '{16'h8000,   16'h8000,   16'd1,      16'h0000,   1'b0, 1'b0};

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        check("reset_q",    32'(bus.Quotient),    32'h0);
        check("reset_r",    32'(bus.Remainder),   32'h0);
        check("reset_busy", 32'(bus.busy),        32'h0);
        check("reset_done", 32'(bus.done),        32'h0);
        check("reset_dz",   32'(bus.div_by_zero), 32'h0);
        check("reset_ov",   32'(bus.overflow),    32'h0);
        bus.start = 1'b0;
        rst       = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, q, r, dz, ov, dcyc, bz);
            check($sformatf("vec%0d_cycle", i), 32'(dcyc), 32'd18);
            check($sformatf("vec%0d_q", i),     32'(q),    32'(tbl[i].q));
            check($sformatf("vec%0d_r", i),     32'(r),    32'(tbl[i].r));
            check($sformatf("vec%0d_dz", i),    32'(dz),   32'(tbl[i].dz));
            check($sformatf("vec%0d_ov", i),    32'(ov),   32'(tbl[i].ov));
            check($sformatf("vec%0d_busy", i),  32'(bz),   32'h0);
            @(negedge clk);
            check($sformatf("vec%0d_pulse", i), 32'(bus.done),     32'h0);
            check($sformatf("vec%0d_hold", i),  32'(bus.Quotient), 32'(tbl[i].q));
        end

        // Second start while busy must be ignored.
        a1 = 16'hFC18;
        b1 = 16'd9;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a1;
        bus.B     = b1;
        ndone  = 0;
        dfirst = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_c1", 32'(bus.busy), 32'h1);
            if (c == 5) check("busy_c5", 32'(bus.busy), 32'h1);
            bus.start = (c == 5);
            if (c == 5) begin
                bus.A = 16'd50;
                bus.B = 16'd5;
            end
            if (bus.done) begin
                ndone++;
                if (dfirst < 0) begin
                    dfirst = c;
                    q = bus.Quotient;
                    r = bus.Remainder;
                end
            end
        end
        model(a1, b1, eq, er, edz, eov);
        check("ignore_ndone", 32'(ndone),  32'd1);
        check("ignore_cycle", 32'(dfirst), 32'd18);
        check("ignore_q",     32'(q),      32'(eq));
        check("ignore_r",     32'(r),      32'(er));

        // start held high: accepted on each done cycle.
        a1 = 16'hFB2E;
        b1 = 16'd5;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a1;
        bus.B     = b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dpos.push_back(c);
                q = bus.Quotient;
                r = bus.Remainder;
            end
            if (c == 54) bus.start = 1'b0;
        end
        model(a1, b1, eq, er, edz, eov);
        check("held_ndone", 32'(dpos.size()), 32'd3);
        for (int k = 0; k < dpos.size() && k < 3; k++) begin
            check($sformatf("held_pos%0d", k), 32'(dpos[k]), 32'(18 * (k + 1)));
        end
        check("held_q", 32'(q), 32'(eq));
        check("held_r", 32'(r), 32'(er));

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'd1000;
        bus.B     = 16'd3;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst       = (c == 9);
            if (bus.done) ndone++;
        end
        check("abort_ndone", 32'(ndone),           32'd0);
        check("abort_q",     32'(bus.Quotient),    32'h0);
        check("abort_r",     32'(bus.Remainder),   32'h0);
        check("abort_busy",  32'(bus.busy),        32'h0);
        check("abort_dz",    32'(bus.div_by_zero), 32'h0);
        check("abort_ov",    32'(bus.overflow),    32'h0);
        run_op(16'd1000, 16'd3, q, r, dz, ov, dcyc, bz);
        check("after_abort_cycle", 32'(dcyc), 32'd18);
        check("after_abort_q",     32'(q),    32'd333);
        check("after_abort_r",     32'(r),    32'd1);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom_range(0, 40) - 20) : 16'($urandom);
            if (rb == 16'h0000) rb = 16'd1;
            if (ra == 16'h8000 && rb == 16'hFFFF) rb = 16'd1;
            model(ra, rb, eq, er, edz, eov);
            run_op(ra, rb, q, r, dz, ov, dcyc, bz);
            check("rand_cycle", 32'(dcyc), 32'd18);
            check("rand_q",     32'(q),    32'(eq));
            check("rand_r",     32'(r),    32'(er));
            check("rand_flags", 32'({dz, ov}), 32'h0);
            ai = int'($signed(ra));
            bi = int'($signed(rb));
            qi = int'($signed(q));
            ri = int'($signed(r));
            check("rand_identity",
                  32'((ai == qi * bi + ri) && ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi))),
                  32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
